stack_host_driver: RTL and testbench
====================================

# stack_host_driver

Initiator side of the external stack-chip bus. Accepts push/pop requests from on-chip logic over a valid/ready request channel and sequences the stack's push/pop strobes, shared 8-bit data bus and instruction-done handshake. It tracks stack depth, rejecting overflow and underflow locally without bus activity, and returns pop data or error status on a valid/ready response channel.

## Interface
- DATA_W, 8, data bus width
- DEPTH, 32, stack capacity in entries
- GAP, 2, minimum cycles after strobe before done is sampled (≥1)
- TIMEOUT, 255, max cycles waiting for done before abort (≥1)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_op  in  1  0=push, 1=pop
- req_data  in  DATA_W  push data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  DATA_W  popped value; 0 for push or error
- rsp_err  out  2  00 ok, 01 overflow, 10 underflow, 11 timeout
- stk_push  out  1  push strobe to stack
- stk_pop  out  1  pop strobe to stack
- stk_data_out  out  DATA_W  data driven to stack bus
- stk_data_oe  out  1  1 = host drives bus
- stk_data_in  in  DATA_W  data read from stack bus
- stk_done  in  1  stack instruction-done, high when stack idle
- depth  out  clog2(DEPTH+1)  current entry count
- full  out  1  depth==DEPTH
- empty  out  1  depth==0

## Operation
- States: IDLE, SETUP, STROBE, GAP_WAIT, WAIT_DONE, CAPTURE, RESP.
- IDLE: req_ready=1 (only here). On accept, latch op/data.
  - push with full, or pop with empty: go directly to RESP with err 01/10; no strobe, no oe.
  - otherwise -> SETUP.
- SETUP (1 cycle): push: stk_data_oe=1, stk_data_out=latched data. Pop: oe=0.
- STROBE (1 cycle): stk_push or stk_pop =1 for exactly this cycle; push keeps oe/data.
- GAP_WAIT: GAP cycles, done ignored; push keeps oe/data.
- WAIT_DONE: counter counts cycles; stk_done=1 -> push: RESP ok, depth+1; pop: CAPTURE. Counter reaches TIMEOUT with done still 0 -> RESP err 11, depth unchanged.
- CAPTURE (1 cycle): latch stk_data_in into rsp_data, depth-1, -> RESP.
- RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready; on handshake -> IDLE.
- stk_data_oe deasserts on the cycle leaving WAIT_DONE; oe=0 in all other states.
- depth saturates by construction: never exceeds DEPTH, never below 0; full/empty combinational from depth.
- stk_push and stk_pop never both 1.

## Timing
- Reset values: req_ready=0 during rst, 1 first cycle after; rsp_valid=0, rsp_data=0, rsp_err=00, stk_push=0, stk_pop=0, stk_data_out=0, stk_data_oe=0, depth=0, full=0, empty=1; state IDLE.
- Reset mid-operation aborts immediately; strobes and oe drop at the reset edge; depth returns to 0 (stack chip must share rst).
- Accept at edge T: SETUP T+1, STROBE T+2, GAP_WAIT T+3..T+2+GAP, first done sample T+3+GAP.
- Done already high at first sample (GAP=2): push rsp_valid at T+6; pop rsp_valid at T+7.
- Reject (overflow/underflow): rsp_valid at T+1.
- Timeout: rsp_valid TIMEOUT cycles after entering WAIT_DONE.
- Back-to-back: next request accepted no earlier than cycle after response handshake.
- rsp_ready held low: FSM stalls in RESP, no new accept.

## Test plan
- Reset then push 0xA5, stk_done=1: oe=1 from T+1, stk_push pulse only at T+2, rsp_valid T+6 err 00, depth=1, empty=0.
- Push 0xA5 then pop, stack returns 0xA5 on stk_data_in: stk_pop single pulse, oe=0 throughout, rsp_data=0xA5 err 00, depth=0, empty=1.
- Pop after reset: rsp err 10 at T+1, rsp_data=0, no stk_pop, depth 0.
- 32 pushes (0x00..0x1F) then 33rd push: full=1 after 32nd; 33rd err 01, no stk_push, depth stays 32.
- Hold stk_done=0 after push strobe: err 11 exactly TIMEOUT cycles after WAIT_DONE entry, oe drops, depth unchanged; rsp_ready low 5 cycles keeps rsp_valid/data stable and req_ready=0.
- Assert rst during WAIT_DONE of a push: next cycle stk_push=0, oe=0, rsp_valid=0, depth=0, req_ready=1 after release.

Source files
------------

// File: rtl/stack_host_driver.sv
// Host-side sequencer for the external stack chip: request/response channels
// in front, push/pop strobes, shared data bus and done handshake behind.
module stack_host_driver #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 32,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255,
    localparam int DPW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_err,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_data_out,
    output logic              stk_data_oe,
    input  logic [DATA_W-1:0] stk_data_in,
    input  logic              stk_done,
    output logic [DPW-1:0]    depth,
    output logic              full,
    output logic              empty
);

    localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_OVER  = 2'b01;
    localparam logic [1:0] ERR_UNDER = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP_WAIT,
        S_WAIT_DONE,
        S_CAPTURE,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DPW-1:0]    depth_q, depth_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic              oe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 1'b0;
            data_q     <= '0;
            cnt_q      <= '0;
            depth_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_OK;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            depth_q    <= depth_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        depth_d    = depth_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        oe         = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    data_d     = req_data;
                    rsp_data_d = '0;
                    cnt_d      = '0;
                    // Capacity violations are answered locally, no bus cycle.
                    if (!req_op && depth_q == DPW'(DEPTH)) begin
                        rsp_err_d = ERR_OVER;
                        state_d   = S_RESP;
                    end else if (req_op && depth_q == '0) begin
                        rsp_err_d = ERR_UNDER;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                oe      = !op_q;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                oe       = !op_q;
                stk_push = !op_q;
                stk_pop  = op_q;
                cnt_d    = '0;
                state_d  = S_GAP_WAIT;
            end
            S_GAP_WAIT: begin
                oe = !op_q;
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                oe = !op_q;
                if (stk_done) begin
                    if (op_q) begin
                        state_d = S_CAPTURE;
                    end else begin
                        rsp_err_d = ERR_OK;
                        depth_d   = depth_q + DPW'(1);
                        state_d   = S_RESP;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_err_d = ERR_TMO;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                rsp_data_d = stk_data_in;
                rsp_err_d  = ERR_OK;
                depth_d    = depth_q - DPW'(1);
                state_d    = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready    = (state_q == S_IDLE) && !rst;
    assign stk_data_oe  = oe;
    assign stk_data_out = oe ? data_q : '0;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign depth        = depth_q;
    assign full         = (depth_q == DPW'(DEPTH));
    assign empty        = (depth_q == '0);

endmodule

// File: tb/tb_stack_host_driver.sv
// Randomized bench for stack_host_driver with a stack-chip emulator and a
// queue-based reference model of the host-visible behaviour.
module tb_stack_host_driver;

    localparam int DW      = 8;
    localparam int DEPTH   = 32;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 255;
    localparam int DPW     = $clog2(DEPTH + 1);

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic           req_op;
    logic [DW-1:0]  req_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [DW-1:0]  rsp_data;
    logic [1:0]     rsp_err;
    logic           stk_push;
    logic           stk_pop;
    logic [DW-1:0]  stk_data_out;
    logic           stk_data_oe;
    logic [DW-1:0]  stk_data_in;
    logic           stk_done;
    logic [DPW-1:0] depth;
    logic           full;
    logic           empty;

    stack_host_driver #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .GAP    (GAP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .stk_push    (stk_push),
        .stk_pop     (stk_pop),
        .stk_data_out(stk_data_out),
        .stk_data_oe (stk_data_oe),
        .stk_data_in (stk_data_in),
        .stk_done    (stk_done),
        .depth       (depth),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stack chip emulator: busy for busy_cfg cycles after each strobe;
    // stuck mode never raises done and leaves its contents untouched.
    logic [DW-1:0] chip[$];
    int busy;
    int busy_cfg;
    bit stuck;
    int n_push;
    int n_pop;
    int n_both;

    always @(posedge clk) begin
        if (rst) begin
            chip.delete();
            busy        <= 0;
            stk_data_in <= '0;
        end else begin
            if (stk_push && stk_pop) n_both <= n_both + 1;
            if (stk_push) begin
                n_push <= n_push + 1;
                if (!stuck && chip.size() < DEPTH) chip.push_back(stk_data_out);
            end
            if (stk_pop) begin
                n_pop <= n_pop + 1;
                if (!stuck && chip.size() > 0) stk_data_in <= chip.pop_back();
            end
            if (stk_push || stk_pop) busy <= busy_cfg;
            else if (busy > 0) busy <= busy - 1;
        end
    end

    assign stk_done = !stuck && (busy == 0);

    logic [DW-1:0] model[$];

    // Issue one request from a negedge, follow it to its response and
    // compare timing, bus activity and the result with the model.
    task automatic do_req(input bit op, input logic [DW-1:0] d, input int b,
                          input bit stk, input int stall);
        int exp_err;
        int exp_data;
        int exp_lat;
        int lat;
        int bad;
        int p0;
        int q0;
        int w;
        bit rej;
        bit e_oe;
        busy_cfg = b;
        stuck    = stk;
        rej      = 0;
        exp_data = 0;
        if (!op) begin
            if (model.size() == DEPTH) begin
                exp_err = 1;
                rej = 1;
            end else if (stk) begin
                exp_err = 3;
            end else begin
                exp_err = 0;
                model.push_back(d);
            end
        end else begin
            if (model.size() == 0) begin
                exp_err = 2;
                rej = 1;
            end else if (stk) begin
                exp_err = 3;
            end else begin
                exp_err = 0;
                exp_data = int'(model.pop_back());
            end
        end
        if (rej) exp_lat = 1;
        else if (stk) exp_lat = 3 + GAP + TIMEOUT;
        else exp_lat = (op ? 5 : 4) + GAP + ((b > GAP) ? b - GAP : 0);

        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        w = 0;
        while (!req_ready) begin
            if (w >= 50) begin
                check("accept_wait", 0, 1);
                req_valid = 1'b0;
                return;
            end
            w++;
            @(negedge clk);
        end
        p0 = n_push;
        q0 = n_pop;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        bad = 0;
        for (int c = 1; c <= 400; c++) begin
            e_oe = !op && !rej && (c < exp_lat);
            if (stk_data_oe !== e_oe) bad++;
            if (e_oe && stk_data_out !== d) bad++;
            if (stk_push !== (!op && !rej && c == 2)) bad++;
            if (stk_pop !== (op && !rej && c == 2)) bad++;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        check("latency", lat, exp_lat);
        check("bus_seq_errors", bad, 0);
        if (lat == 0) return;
        check("rsp_err", rsp_err, exp_err);
        check("rsp_data", rsp_data, exp_data);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, exp_data);
            check("stall_err", rsp_err, exp_err);
            check("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_after", rsp_valid, 0);
        check("push_strobes", n_push - p0, (!op && !rej) ? 1 : 0);
        check("pop_strobes", n_pop - q0, (op && !rej) ? 1 : 0);
        check("depth", depth, model.size());
        check("full", full, model.size() == DEPTH);
        check("empty", empty, model.size() == 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_data  = '0;
        rsp_ready = 1'b0;
        busy_cfg  = 0;
        stuck     = 0;
        n_push    = 0;
        n_pop     = 0;
        n_both    = 0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready_after", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_strobes", {stk_push, stk_pop}, 0);
        check("rst_oe", stk_data_oe, 0);
        check("rst_data_out", stk_data_out, 0);
        check("rst_depth", depth, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);

        do_req(1'b0, 8'hA5, 0, 1'b0, 0);
        do_req(1'b1, 8'h00, 0, 1'b0, 0);
        do_req(1'b1, 8'h00, 0, 1'b0, 1);
        do_req(1'b0, 8'h3C, 0, 1'b1, 5);

        for (int i = 0; i < DEPTH; i++)
            do_req(1'b0, DW'(i), $urandom_range(0, 4), 1'b0, 0);
        do_req(1'b0, 8'hEE, 0, 1'b0, 2);
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 8'h00, $urandom_range(0, 5), 1'b0, 0);

        for (int i = 0; i < 80; i++) begin
            do_req($urandom_range(0, 9) < 4, DW'($urandom),
                   $urandom_range(0, 5), $urandom_range(0, 19) == 0,
                   $urandom_range(0, 3));
        end
        stuck = 0;

        busy_cfg  = 0;
        stuck     = 1;
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_push", stk_push, 0);
        check("mid_rst_oe", stk_data_oe, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_depth", depth, 0);
        check("mid_rst_req_ready", req_ready, 0);
        rst   = 1'b0;
        stuck = 0;
        model.delete();
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_empty", empty, 1);
        do_req(1'b0, 8'h5A, 1, 1'b0, 0);
        do_req(1'b1, 8'h00, 3, 1'b0, 0);

        check("push_pop_overlap", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
